// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Optional build macro used by the transmit core: UART_TX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    B9600   = 2'h0,
    B38400  = 2'h1,
    B115200 = 2'h2
  } baud_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Rounded clocks-per-bit for a CTRL.BAUD code; the reserved code falls back to 9600.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [1:0]  baud_sel);
    int unsigned baud;
    case (baud_sel)
      B38400:  baud = 32'd38400;
      B115200: baud = 32'd115200;
      default: baud = 32'd9600;
    endcase
    return (clk_freq + baud / 32'd2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Write handshake from the CSR block into the transmit FIFO.
interface uart_tx_core_if;
  import uart_pkg::*;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read and registered full/empty flags.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  // Storage array; no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: FIFO-fed 8N1 serialiser with run control and done interrupt.
// Build macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_core_if.slave      wr,
  input  logic [1:0]         baud_sel,
  input  logic               tx_en,
  input  logic               tx_start,
  output logic               txd,
  output logic               busy,
  output logic               fifo_full,
  output logic               tx_irq
);

  localparam int unsigned DIV_9600   = baud_div(CLK_FREQ, 2'h0);
  localparam int unsigned DIV_38400  = baud_div(CLK_FREQ, 2'h1);
  localparam int unsigned DIV_115200 = baud_div(CLK_FREQ, 2'h2);
  // 9600 has the largest divisor, so it sizes the bit counter.
  localparam int unsigned CNT_W      = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;

  localparam logic [CNT_W-1:0] RELOAD_9600   = CNT_W'(DIV_9600 - 1);
  localparam logic [CNT_W-1:0] RELOAD_38400  = CNT_W'(DIV_38400 - 1);
  localparam logic [CNT_W-1:0] RELOAD_115200 = CNT_W'(DIV_115200 - 1);

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   reload_sel;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [2:0]         bit_q, bit_d;
  logic               run_q, run_d;
  logic               txd_d, busy_d, irq_d;
  logic               load_c;
  logic               bit_end;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_data;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr.wr_valid),
    .push_data (wr.wr_data),
    .pop       (load_c),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr.wr_ready = ~fifo_full;

  // Bit-period reload value for the currently selected baud code.
  always_comb begin
    reload_sel = RELOAD_9600;
    case (baud_sel)
      B38400:  reload_sel = RELOAD_38400;
      B115200: reload_sel = RELOAD_115200;
      default: reload_sel = RELOAD_9600;
    endcase
  end

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    run_d   = run_q;
    txd_d   = txd;
    irq_d   = 1'b0;
    load_c  = 1'b0;
    bit_end = (cnt_q == '0);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (!tx_en)        run_d = 1'b0;
    else if (tx_start) run_d = 1'b1;

    if ((state_q != ST_IDLE) && !bit_end) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if ((run_q || tx_start) && tx_en && !fifo_empty) load_c = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          txd_d   = sh_q[0];
          sh_d    = {1'b0, sh_q[DATA_W-1:1]};
          bit_d   = '0;
          cnt_d   = div_q;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = par_q;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = sh_q[0];
            sh_d  = {1'b0, sh_q[DATA_W-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          cnt_d   = div_q;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          irq_d = fifo_empty;
          if (fifo_empty && !tx_start) run_d = 1'b0;
          if (run_q && tx_en && !fifo_empty) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame start: pop the head byte and latch the baud selection for the whole frame.
    if (load_c) begin
      state_d = ST_START;
      txd_d   = 1'b0;
      sh_d    = fifo_data;
      div_d   = reload_sel;
      cnt_d   = reload_sel;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_data;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= RELOAD_9600;
      sh_q   <= '0;
      bit_q  <= '0;
      run_q  <= 1'b0;
      txd    <= 1'b1;
      busy   <= 1'b0;
      tx_irq <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      run_q  <= run_d;
      txd    <= txd_d;
      busy   <= busy_d;
      tx_irq <= irq_d;
`ifdef UART_TX_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus queues expected frames, a monitor decodes txd.
module tb_uart_tx_core;

  localparam int CLK_HZ = 1152000;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
    bit         last;
    bit         trunc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] baud_sel;
  logic       tx_en;
  logic       tx_start;
  logic       txd;
  logic       busy;
  logic       fifo_full;
  logic       tx_irq;

  uart_tx_core_if wr_if ();

  uart_tx_core #(
    .CLK_FREQ   (CLK_HZ),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr_if),
    .baud_sel  (baud_sel),
    .tx_en     (tx_en),
    .tx_start  (tx_start),
    .txd       (txd),
    .busy      (busy),
    .fifo_full (fifo_full),
    .tx_irq    (tx_irq)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   irq_cnt = 0;
  int   exp_irq = 0;
  bit   mon_busy = 1'b0;
  exp_t sb [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_irq === 1'b1) irq_cnt <= irq_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rounded clocks per bit from the CTRL.BAUD rate table.
  function automatic int model_div(input int sel);
    int rate;
    case (sel)
      1:       rate = 38400;
      2:       rate = 115200;
      default: rate = 9600;
    endcase
    return (CLK_HZ + rate / 2) / rate;
  endfunction

  // Line levels of one frame, bit 0 first: start, data LSB first, [parity], stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = (($countones(d) % 2) == 1);
`endif
    return f;
  endfunction

  // Monitor: decodes each frame on txd and compares against the scoreboard head.
  initial begin
    bit          have_edge;
    int          start_cyc;
    int          last_end;
    int          glitch;
    int          busy_bad;
    int          n;
    logic [10:0] got;
    logic [10:0] expv;
    exp_t        e;
    have_edge = 1'b0;
    last_end  = -100;
    forever begin
      if (!have_edge) @(negedge clk);
      have_edge = 1'b0;
      if (rst === 1'b0 && txd === 1'b0) begin
        mon_busy  = 1'b1;
        start_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_frame", 1, 0);
          n = 0;
          while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
        end else begin
          e = sb.pop_front();
          if (e.trunc) begin
            n = 0;
            while (rst !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
          end else begin
            if (e.b2b) check("b2b_gap", start_cyc - last_end, 1);
            expv     = exp_frame(e.data);
            got      = '1;
            glitch   = 0;
            busy_bad = 0;
            for (int b = 0; b < NBITS; b++) begin
              for (int k = 0; k < e.div; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (k == e.div / 2) got[b] = txd;
                if (txd !== expv[b]) glitch++;
                if (busy !== 1'b1) busy_bad++;
              end
            end
            last_end = cyc;
            check("frame_bits", got, expv);
            check("bit_timing", glitch, 0);
            check("busy_in_frame", busy_bad, 0);
            @(negedge clk);
            have_edge = 1'b1;
            check("irq_at_end", tx_irq, e.last);
            if (e.last) check("busy_after_last", busy, 0);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int div, input bit b2b,
                              input bit last, input bit trunc);
    exp_t e;
    e.data = d; e.div = div; e.b2b = b2b; e.last = last; e.trunc = trunc;
    sb.push_back(e);
    if (last) exp_irq++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) begin
      check("drain_timeout", n, 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    logic [7:0] b0, b1;
    int         sel, nb;
    rst            = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    tx_en          = 1'b0;
    tx_start       = 1'b0;
    baud_sel       = 2'd2;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_wr_ready", wr_if.wr_ready, 1);
    check("rst_irq", tx_irq, 0);
    rst   = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame at 115200 with one-cycle start latency.
    expect_frame(8'hA5, model_div(2), 1'b0, 1'b1, 1'b0);
    write_byte(8'hA5);
    pulse_start();
    check("start_latency_txd", txd, 0);
    check("start_latency_busy", busy, 1);
    drain(400);
    check("irq_count_single", irq_cnt, exp_irq);

    // Three queued bytes sent back-to-back.
    expect_frame(8'h00, model_div(2), 1'b0, 1'b0, 1'b0);
    expect_frame(8'hFF, model_div(2), 1'b1, 1'b0, 1'b0);
    expect_frame(8'h55, model_div(2), 1'b1, 1'b1, 1'b0);
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h55);
    pulse_start();
    drain(1000);
    check("irq_count_burst", irq_cnt, exp_irq);

    // Fill to full; the ninth write is dropped.
    for (int i = 0; i < 9; i++) begin
      b0 = 8'($urandom);
      if (i < 8) expect_frame(b0, model_div(2), i > 0, i == 7, 1'b0);
      write_byte(b0);
      if (i == 6) check("not_full_at_7", fifo_full, 0);
      if (i == 7) begin
        check("full_at_8", fifo_full, 1);
        check("wr_ready_at_8", wr_if.wr_ready, 0);
      end
      if (i == 8) check("full_after_drop", fifo_full, 1);
    end
    pulse_start();
    drain(3000);
    check("irq_count_fill", irq_cnt, exp_irq);

    // Baud change mid-frame applies only to the next frame.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    expect_frame(b0, model_div(2), 1'b0, 1'b0, 1'b0);
    expect_frame(b1, model_div(0), 1'b1, 1'b1, 1'b0);
    write_byte(b0);
    write_byte(b1);
    pulse_start();
    repeat (35) @(negedge clk);
    baud_sel = 2'd0;
    drain(3000);
    baud_sel = 2'd2;

    // tx_en dropped during DATA: frame completes, second byte held back.
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    expect_frame(b0, model_div(2), 1'b0, 1'b0, 1'b0);
    write_byte(b0);
    write_byte(b1);
    pulse_start();
    repeat (30) @(negedge clk);
    tx_en = 1'b0;
    drain(400);
    repeat (100) @(negedge clk);
    check("txen_off_busy", busy, 0);
    check("txen_off_txd", txd, 1);
    tx_en = 1'b1;
    repeat (50) @(negedge clk);
    check("txen_on_no_start_busy", busy, 0);
    expect_frame(b1, model_div(2), 1'b0, 1'b1, 1'b0);
    pulse_start();
    drain(400);
    check("irq_count_txen", irq_cnt, exp_irq);

    // Reset mid-frame truncates the frame and empties the FIFO.
    b0 = 8'($urandom);
    expect_frame(b0, model_div(2), 1'b0, 1'b0, 1'b1);
    write_byte(b0);
    write_byte(8'($urandom));
    pulse_start();
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_full", fifo_full, 0);
    check("midrst_wr_ready", wr_if.wr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    repeat (50) @(negedge clk);
    check("after_rst_busy", busy, 0);
    check("after_rst_sb_empty", sb.size(), 0);
    tx_en = 1'b0;
    @(negedge clk);
    tx_en = 1'b1;

    // Parity-relevant patterns (odd and even number of ones).
    expect_frame(8'h07, model_div(2), 1'b0, 1'b0, 1'b0);
    expect_frame(8'h03, model_div(2), 1'b1, 1'b1, 1'b0);
    write_byte(8'h07);
    write_byte(8'h03);
    pulse_start();
    drain(800);

    // Randomised bursts over all baud codes including the reserved one.
    for (int r = 0; r < 6; r++) begin
      sel      = int'($urandom_range(0, 3));
      nb       = int'($urandom_range(1, 3));
      baud_sel = 2'(sel);
      for (int i = 0; i < nb; i++) begin
        b0 = 8'($urandom);
        expect_frame(b0, model_div(sel), i > 0, i == nb - 1, 1'b0);
        write_byte(b0);
      end
      pulse_start();
      drain(nb * NBITS * 130 + 200);
    end

    check("irq_count_total", irq_cnt, exp_irq);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
